// File: rtl/led_pattern_ctrl.sv
// LED pattern controller: synchronized 1 Hz tick steps a mode-dependent LED pattern; a button cycles modes.
// Optional button debounce is compiled in with macro LED_PATTERN_DEBOUNCE_EN (default build: no debounce).
module led_pattern_ctrl #(
  parameter int NUM_LEDS        = 8,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                tick_in,
  input  logic                btn_mode,
  input  logic                enable,
  output logic [NUM_LEDS-1:0] led,
  output logic [1:0]          mode,
  output logic                step
);

  localparam logic [1:0] ST_OFF    = 2'd0;
  localparam logic [1:0] ST_BLINK  = 2'd1;
  localparam logic [1:0] ST_SHIFT  = 2'd2;
  localparam logic [1:0] ST_BOUNCE = 2'd3;

  logic                r_tick_s1, r_tick_s2, r_tick_prev;
  logic                r_btn_s1, r_btn_s2, r_btn_prev;
  logic                w_btn_db;
  logic                w_tick_rise, w_btn_rise;
  logic [1:0]          r_mode, w_mode_nxt;
  logic [NUM_LEDS-1:0] r_led, w_next_led, w_init_led;
  logic                r_dir_up, w_next_dir;
  logic                r_step;

  // Tick and button both cross in from asynchronous sources.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_s1   <= 1'b0;
      r_tick_s2   <= 1'b0;
      r_tick_prev <= 1'b0;
      r_btn_s1    <= 1'b0;
      r_btn_s2    <= 1'b0;
    end else begin
      r_tick_s1   <= tick_in;
      r_tick_s2   <= r_tick_s1;
      r_tick_prev <= r_tick_s2;
      r_btn_s1    <= btn_mode;
      r_btn_s2    <= r_btn_s1;
    end
  end

  assign w_tick_rise = r_tick_s2 & ~r_tick_prev;

`ifdef LED_PATTERN_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [CNT_W-1:0] r_db_cnt;
  logic             r_btn_db;

  // Counter tracks how long the synchronized level has disagreed with the accepted level.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_db_cnt <= '0;
      r_btn_db <= 1'b0;
    end else if (r_btn_s2 == r_btn_db) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      r_db_cnt <= '0;
      r_btn_db <= r_btn_s2;
    end else begin
      r_db_cnt <= r_db_cnt + CNT_W'(1);
    end
  end

  assign w_btn_db = r_btn_db;
`else
  assign w_btn_db = r_btn_s2;
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) r_btn_prev <= 1'b0;
    else        r_btn_prev <= w_btn_db;
  end

  assign w_btn_rise = w_btn_db & ~r_btn_prev;
  assign w_mode_nxt = r_mode + 2'd1;

  always_comb begin
    w_init_led = '0;
    case (w_mode_nxt)
      ST_OFF:    w_init_led = '0;
      ST_BLINK:  w_init_led = '1;
      ST_SHIFT:  w_init_led = NUM_LEDS'(1);
      ST_BOUNCE: w_init_led = NUM_LEDS'(1);
      default:   w_init_led = '0;
    endcase
  end

  // Direction flips on the step that lands on an end bit, so end values never repeat.
  always_comb begin
    w_next_led = r_led;
    w_next_dir = r_dir_up;
    case (r_mode)
      ST_OFF:   w_next_led = '0;
      ST_BLINK: w_next_led = ~r_led;
      ST_SHIFT: w_next_led = {r_led[NUM_LEDS-2:0], r_led[NUM_LEDS-1]};
      ST_BOUNCE: begin
        if (r_led == '0) begin
          w_next_led = NUM_LEDS'(1);
          w_next_dir = 1'b1;
        end else if (r_dir_up) begin
          w_next_led = r_led << 1;
          if (r_led[NUM_LEDS-2]) w_next_dir = 1'b0;
        end else begin
          w_next_led = r_led >> 1;
          if (r_led[1]) w_next_dir = 1'b1;
        end
      end
      default: w_next_led = r_led;
    endcase
  end

  // A mode change overrides a coincident step; the step pulse itself is still emitted.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_mode   <= ST_OFF;
      r_led    <= '0;
      r_dir_up <= 1'b1;
      r_step   <= 1'b0;
    end else begin
      r_step <= w_tick_rise & enable;
      if (w_btn_rise) begin
        r_mode   <= w_mode_nxt;
        r_led    <= w_init_led;
        r_dir_up <= 1'b1;
      end else if (w_tick_rise && enable) begin
        r_led    <= w_next_led;
        r_dir_up <= w_next_dir;
      end
    end
  end

  assign led  = r_led;
  assign mode = r_mode;
  assign step = r_step;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed self-checking bench for led_pattern_ctrl (NUM_LEDS=8, DEBOUNCE_CYCLES=4).
module tb_led_pattern_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_in = 1'b0;
  logic       btn_mode = 1'b0;
  logic       enable = 1'b1;
  logic [7:0] led;
  logic [1:0] mode;
  logic       step;

  int n_chk = 0;
  int n_err = 0;

`ifdef LED_PATTERN_DEBOUNCE_EN
  localparam int BTN_LAT = 7;
  localparam logic [1:0] GLITCH_MODE = 2'd2;
`else
  localparam int BTN_LAT = 3;
  localparam logic [1:0] GLITCH_MODE = 2'd3;
`endif

  led_pattern_ctrl #(.NUM_LEDS(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .tick_in(tick_in), .btn_mode(btn_mode),
    .enable(enable), .led(led), .mode(mode), .step(step)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk_in); #1; end
  endtask

  // One tick_in pulse; counts step pulses and records the edge of the first one.
  task automatic tick(input string tag, input logic [7:0] exp_led, input int exp_n);
    int n, first;
    n = 0; first = -1;
    tick_in = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk_in); #1;
      if (c == 5) tick_in = 1'b0;
      if (step) begin
        n++;
        if (first < 0) first = c;
      end
    end
    check({tag, " steps"}, n, exp_n);
    if (exp_n > 0) check({tag, " latency"}, first, 3);
    check({tag, " led"}, {24'd0, led}, {24'd0, exp_led});
  endtask

  task automatic press(input string tag, input logic [1:0] exp_mode, input logic [7:0] exp_led);
    btn_mode = 1'b1;
    cyc(10);
    btn_mode = 1'b0;
    cyc(10);
    check({tag, " mode"}, {30'd0, mode}, {30'd0, exp_mode});
    check({tag, " led"}, {24'd0, led}, {24'd0, exp_led});
  endtask

  logic [7:0] shift_exp [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  logic [7:0] bounce_exp [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                  8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

  initial begin
    int n, first;
    // Reset held while tick toggles
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 0) tick_in = ~tick_in;
      cyc(1);
      if (i % 4 == 3) begin
        check("rst led", {24'd0, led}, 32'h0);
        check("rst mode", {30'd0, mode}, 32'h0);
        check("rst step", {31'd0, step}, 32'h0);
      end
    end
    tick_in = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(4);

    // OFF -> BLINK -> SHIFT, then rotate
    press("p1", 2'd1, 8'hFF);
    press("p2", 2'd2, 8'h01);
    for (int i = 0; i < 8; i++) tick($sformatf("shift%0d", i), shift_exp[i], 1);

    // BOUNCE
    press("p3", 2'd3, 8'h01);
    for (int i = 0; i < 15; i++) tick($sformatf("bounce%0d", i), bounce_exp[i], 1);

    // OFF still steps, then BLINK inverts
    press("p4", 2'd0, 8'h00);
    tick("off", 8'h00, 1);
    press("p5", 2'd1, 8'hFF);
    tick("blink0", 8'h00, 1);
    tick("blink1", 8'hFF, 1);

    // Press coincident with a step: mode change wins, step still pulses
    btn_mode = 1'b1;
    cyc(BTN_LAT - 3);
    tick_in = 1'b1;
    cyc(3);
    check("coin mode", {30'd0, mode}, 32'd2);
    check("coin led", {24'd0, led}, 32'h01);
    check("coin step", {31'd0, step}, 32'd1);
    cyc(3);
    btn_mode = 1'b0;
    tick_in = 1'b0;
    cyc(12);

    // 3-cycle button glitch
    btn_mode = 1'b1;
    cyc(3);
    btn_mode = 1'b0;
    cyc(12);
    check("glitch mode", {30'd0, mode}, {30'd0, GLITCH_MODE});
    check("glitch led", {24'd0, led}, 32'h01);
    tick("pre0", 8'h02, 1);
    tick("pre1", 8'h04, 1);
    tick("pre2", 8'h08, 1);

    // Frozen while disabled
    enable = 1'b0;
    for (int i = 0; i < 5; i++) tick($sformatf("frozen%0d", i), 8'h08, 0);

    // Asynchronous reset mid-pattern
    #2 rst_n = 1'b0;
    #1;
    check("arst led", {24'd0, led}, 32'h0);
    check("arst mode", {30'd0, mode}, 32'h0);
    check("arst step", {31'd0, step}, 32'h0);

    // tick_in high at reset release -> exactly one step three edges later
    tick_in = 1'b1;
    enable = 1'b1;
    cyc(2);
    check("arst hold led", {24'd0, led}, 32'h0);
    rst_n = 1'b1;
    n = 0; first = -1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk_in); #1;
      if (step) begin
        n++;
        if (first < 0) first = c;
      end
    end
    check("rel steps", n, 1);
    check("rel latency", first, 3);
    tick_in = 1'b0;
    cyc(4);

    // Mode change accepted while disabled
    enable = 1'b0;
    press("dis press", 2'd1, 8'hFF);
    tick("dis tick", 8'hFF, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
